// File: rtl/nnrv_pkg.sv
// rtl/nnrv_pkg.sv - shared constants and index helpers for the nnrv register file
package nnrv_pkg;

  localparam int REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;
  localparam int XLEN_DEFAULT = 32;
  localparam int MAX_PORTS = 8;
  localparam int IDX_BUS_W = REG_IDX_W * MAX_PORTS;

  // Flat index buses are zero-padded to IDX_BUS_W so one helper serves every port count.
  function automatic logic [REG_IDX_W-1:0] idx_slice(input logic [IDX_BUS_W-1:0] vec,
                                                     input int k);
    return vec[k*REG_IDX_W +: REG_IDX_W];
  endfunction

  function automatic logic idx_in_range(input logic [REG_IDX_W-1:0] idx, input int reg_num);
    return (idx != REG_ZERO) && (int'(idx) < reg_num);
  endfunction

endpackage

// File: rtl/nnrv_regfile_sb.sv
// rtl/nnrv_regfile_sb.sv - per-register busy scoreboard: flush > reserve > write clear > hold
module nnrv_regfile_sb
  import nnrv_pkg::*;
#(
  parameter int REG_NUM = 32,
  parameter int NW      = 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_rsv_en,
  input  logic [REG_IDX_W-1:0]      i_rsv_idx,
  input  logic                      i_flush,
  input  logic [NW-1:0]             i_clr_en,
  input  logic [NW*REG_IDX_W-1:0]   i_clr_idx,
  output logic [REG_NUM-1:0]        o_busy_vec
);

  localparam int RW = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;

  logic [REG_NUM-1:0] busy_q;
  logic [REG_NUM-1:0] busy_nxt;
  logic [REG_IDX_W-1:0] clr_idx [NW];

  for (genvar j = 0; j < NW; j++) begin : g_clr_idx
    assign clr_idx[j] = i_clr_idx[j*REG_IDX_W +: REG_IDX_W];
  end

  // Later assignments override earlier ones, which encodes the priority order directly.
  always_comb begin
    busy_nxt = busy_q;
    for (int j = 0; j < NW; j++) begin
      if (i_clr_en[j]) begin
        busy_nxt[clr_idx[j][RW-1:0]] = 1'b0;
      end
    end
    if (i_rsv_en && idx_in_range(i_rsv_idx, REG_NUM)) begin
      busy_nxt[i_rsv_idx[RW-1:0]] = 1'b1;
    end
    if (i_flush) begin
      busy_nxt = '0;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_nxt;
    end
  end

  assign o_busy_vec = busy_q;

endmodule

// File: rtl/nnrv_regfile_mp.sv
// rtl/nnrv_regfile_mp.sv - multi-port integer register file with optional bypass and scoreboard
module nnrv_regfile_mp
  import nnrv_pkg::*;
#(
  parameter int XLEN    = XLEN_DEFAULT,
  parameter int REG_NUM = 32,
  parameter int NR      = 2,
  parameter int NW      = 1,
  parameter int BYPASS  = 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [NR-1:0]             i_rd_en,
  input  logic [NR*REG_IDX_W-1:0]   i_rd_idx,
  output logic [NR*XLEN-1:0]        o_rd_data,
  output logic [NR-1:0]             o_rd_busy,
  input  logic [NW-1:0]             i_w_en,
  input  logic [NW*REG_IDX_W-1:0]   i_w_idx,
  input  logic [NW*XLEN-1:0]        i_w_data,
  input  logic                      i_rsv_en,
  input  logic [REG_IDX_W-1:0]      i_rsv_idx,
  input  logic                      i_flush,
  output logic [REG_NUM-1:0]        o_busy_vec
);

  localparam int RW = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;

  logic [IDX_BUS_W-1:0] rd_idx_bus;
  logic [IDX_BUS_W-1:0] w_idx_bus;
  logic [REG_IDX_W-1:0] rd_idx [NR];
  logic [REG_IDX_W-1:0] w_idx  [NW];
  logic [NW-1:0]        w_ok;
  logic [XLEN-1:0]      regs   [REG_NUM];
  logic [REG_NUM-1:0]   busy_vec;

  assign rd_idx_bus = IDX_BUS_W'(i_rd_idx);
  assign w_idx_bus  = IDX_BUS_W'(i_w_idx);

  for (genvar k = 0; k < NR; k++) begin : g_rd_idx
    assign rd_idx[k] = idx_slice(rd_idx_bus, k);
  end

  // Writes are gated by reset so nothing issued during reset commits or bypasses.
  for (genvar j = 0; j < NW; j++) begin : g_w_ok
    assign w_idx[j] = idx_slice(w_idx_bus, j);
    assign w_ok[j]  = i_rst && i_w_en[j] && idx_in_range(w_idx[j], REG_NUM);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      for (int r = 0; r < REG_NUM; r++) begin
        regs[r] <= '0;
      end
    end else begin
      for (int j = 0; j < NW; j++) begin
        if (w_ok[j]) begin
          regs[w_idx[j][RW-1:0]] <= i_w_data[j*XLEN +: XLEN];
        end
      end
    end
  end

  // Bypass loop runs low-to-high so the highest write port wins.
  always_comb begin
    o_rd_data = '0;
    o_rd_busy = '0;
    for (int k = 0; k < NR; k++) begin
      if (i_rd_en[k] && idx_in_range(rd_idx[k], REG_NUM)) begin
        o_rd_data[k*XLEN +: XLEN] = regs[rd_idx[k][RW-1:0]];
        o_rd_busy[k]              = busy_vec[rd_idx[k][RW-1:0]];
        if (BYPASS != 0) begin
          for (int j = 0; j < NW; j++) begin
            if (w_ok[j] && (w_idx[j] == rd_idx[k])) begin
              o_rd_data[k*XLEN +: XLEN] = i_w_data[j*XLEN +: XLEN];
              o_rd_busy[k]              = 1'b0;
            end
          end
        end
      end
    end
  end

  nnrv_regfile_sb #(
    .REG_NUM (REG_NUM),
    .NW      (NW)
  ) u_sb (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_rsv_en   (i_rsv_en),
    .i_rsv_idx  (i_rsv_idx),
    .i_flush    (i_flush),
    .i_clr_en   (w_ok),
    .i_clr_idx  (i_w_idx),
    .o_busy_vec (busy_vec)
  );

  assign o_busy_vec = busy_vec;

endmodule

// File: tb/tb_nnrv_regfile_mp.sv
// tb/tb_nnrv_regfile_mp.sv - self-checking bench for nnrv_regfile_mp (bypass and non-bypass builds)
module tb_nnrv_regfile_mp;

  logic        i_clk;
  logic        rstn;
  logic [1:0]  rd_en;
  logic [4:0]  ridx [2];
  logic [1:0]  w_en;
  logic [4:0]  widx [2];
  logic [31:0] wd   [2];
  logic        rsv_en;
  logic [4:0]  rsv_idx;
  logic        flush;

  logic [63:0] rdd_b, rdd_n;
  logic [1:0]  rdb_b, rdb_n;
  logic [31:0] bv_b;
  logic [15:0] bv_n;

  logic [31:0] mdl [32];
  logic [31:0] mbusy;
  int n_checks = 0;
  int n_err = 0;

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  nnrv_regfile_mp #(.XLEN(32), .REG_NUM(32), .NR(2), .NW(2), .BYPASS(1)) u_byp (
    .i_clk(i_clk), .i_rst(rstn), .i_rd_en(rd_en), .i_rd_idx({ridx[1], ridx[0]}),
    .o_rd_data(rdd_b), .o_rd_busy(rdb_b), .i_w_en(w_en), .i_w_idx({widx[1], widx[0]}),
    .i_w_data({wd[1], wd[0]}), .i_rsv_en(rsv_en), .i_rsv_idx(rsv_idx), .i_flush(flush),
    .o_busy_vec(bv_b)
  );

  nnrv_regfile_mp #(.XLEN(32), .REG_NUM(16), .NR(2), .NW(2), .BYPASS(0)) u_nob (
    .i_clk(i_clk), .i_rst(rstn), .i_rd_en(rd_en), .i_rd_idx({ridx[1], ridx[0]}),
    .o_rd_data(rdd_n), .o_rd_busy(rdb_n), .i_w_en(w_en), .i_w_idx({widx[1], widx[0]}),
    .i_w_data({wd[1], wd[0]}), .i_rsv_en(rsv_en), .i_rsv_idx(rsv_idx), .i_flush(flush),
    .o_busy_vec(bv_n)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic written(input logic [4:0] a);
    return rstn && a != 0 && ((w_en[0] && widx[0] == a) || (w_en[1] && widx[1] == a));
  endfunction

  function automatic logic [31:0] exp_data(input int k, input bit byp, input int rn);
    logic [4:0] a;
    logic [31:0] v;
    a = ridx[k];
    if (!rd_en[k] || a == 0 || int'(a) >= rn) return 32'd0;
    v = mdl[a];
    if (byp && written(a)) v = (w_en[1] && widx[1] == a) ? wd[1] : wd[0];
    return v;
  endfunction

  function automatic logic exp_busy(input int k, input bit byp, input int rn);
    logic [4:0] a;
    a = ridx[k];
    if (!rd_en[k] || a == 0 || int'(a) >= rn) return 1'b0;
    if (byp && written(a)) return 1'b0;
    return mbusy[a];
  endfunction

  task automatic model_edge();
    logic [31:0] nb;
    if (!rstn) begin
      for (int r = 0; r < 32; r++) mdl[r] = '0;
      mbusy = '0;
      return;
    end
    nb = '0;
    for (int r = 1; r < 32; r++) begin
      nb[r] = flush ? 1'b0 :
              (rsv_en && rsv_idx == 5'(r)) ? 1'b1 :
              written(5'(r)) ? 1'b0 : mbusy[r];
    end
    for (int j = 0; j < 2; j++) begin
      if (w_en[j] && widx[j] != 0) mdl[widx[j]] = wd[j];
    end
    mbusy = nb;
  endtask

  task automatic idle();
    rstn = 1'b1; rd_en = 2'b00; ridx[0] = 0; ridx[1] = 0;
    w_en = 2'b00; widx[0] = 0; widx[1] = 0; wd[0] = 0; wd[1] = 0;
    rsv_en = 1'b0; rsv_idx = 0; flush = 1'b0;
  endtask

  task automatic cycle();
    @(negedge i_clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("byp_data%0d", k), rdd_b[k*32 +: 32], exp_data(k, 1'b1, 32));
      chk($sformatf("byp_busy%0d", k), 32'(rdb_b[k]), 32'(exp_busy(k, 1'b1, 32)));
      chk($sformatf("nob_data%0d", k), rdd_n[k*32 +: 32], exp_data(k, 1'b0, 16));
      chk($sformatf("nob_busy%0d", k), 32'(rdb_n[k]), 32'(exp_busy(k, 1'b0, 16)));
    end
    @(posedge i_clk);
    model_edge();
    #1;
    chk("byp_busy_vec", bv_b, mbusy);
    chk("nob_busy_vec", 32'(bv_n), {16'd0, mbusy[15:0]});
  endtask

  initial begin
    for (int r = 0; r < 32; r++) mdl[r] = '0;
    mbusy = '0;
    idle();
    rstn = 1'b0;
    cycle();
    idle();
    chk("reset_busy_vec", bv_b, 32'd0);

    for (int r = 1; r < 32; r++) begin
      idle(); w_en = 2'b01; widx[0] = 5'(r); wd[0] = 32'hA5A5_0000 + r;
      rd_en = 2'b11; ridx[0] = 5'(r); ridx[1] = 5'(r - 1);
      cycle();
    end
    idle(); rd_en = 2'b11; ridx[0] = 5'd20; ridx[1] = 5'd9;
    #1;
    chk("filled_x20", rdd_b[31:0], 32'hA5A5_0014);

    // reset pulse with a write and reserve that must both be dropped
    idle(); rstn = 1'b0; w_en = 2'b01; widx[0] = 5'd5; wd[0] = 32'hFFFF_FFFF;
    rsv_en = 1'b1; rsv_idx = 5'd3; rd_en = 2'b11; ridx[0] = 5'd5; ridx[1] = 5'd3;
    cycle();
    for (int r = 0; r < 32; r += 2) begin
      idle(); rd_en = 2'b11; ridx[0] = 5'(r); ridx[1] = 5'(r + 1);
      cycle();
    end
    idle(); rd_en = 2'b11; ridx[0] = 5'd5; ridx[1] = 5'd31;
    #1;
    chk("post_reset_x5", rdd_b[31:0], 32'd0);
    chk("post_reset_x31", rdd_b[63:32], 32'd0);

    idle(); w_en = 2'b01; widx[0] = 5'd0; wd[0] = 32'hDEAD_BEEF;
    rsv_en = 1'b1; rsv_idx = 5'd0; rd_en = 2'b01; ridx[0] = 5'd0;
    cycle();
    idle(); rd_en = 2'b01; ridx[0] = 5'd0;
    #1;
    chk("x0_data", rdd_b[31:0], 32'd0);
    chk("x0_busy_vec", 32'(bv_b[0]), 32'd0);
    cycle();

    idle(); w_en = 2'b01; widx[0] = 5'd5; wd[0] = 32'h1234_5678; rd_en = 2'b10; ridx[1] = 5'd5;
    #1;
    chk("bypass_same_cycle", rdd_b[63:32], 32'h1234_5678);
    chk("nobypass_same_cycle", rdd_n[63:32], 32'd0);
    cycle();
    idle(); rd_en = 2'b10; ridx[1] = 5'd5;
    #1;
    chk("nobypass_next_cycle", rdd_n[63:32], 32'h1234_5678);
    cycle();

    idle(); w_en = 2'b11; widx[0] = 5'd7; widx[1] = 5'd7; wd[0] = 32'h11; wd[1] = 32'h22;
    rd_en = 2'b01; ridx[0] = 5'd7;
    cycle();
    idle(); rd_en = 2'b11; ridx[0] = 5'd7; ridx[1] = 5'd7;
    #1;
    chk("collide_x7_byp", rdd_b[31:0], 32'h22);
    chk("collide_x7_nob", rdd_n[63:32], 32'h22);
    cycle();

    idle(); rsv_en = 1'b1; rsv_idx = 5'd3;
    cycle();
    chk("rsv_x3_vec", 32'(bv_b[3]), 32'd1);
    idle(); rd_en = 2'b01; ridx[0] = 5'd3;
    #1;
    chk("rsv_x3_rd_busy", 32'(rdb_b[0]), 32'd1);
    cycle();
    idle(); w_en = 2'b01; widx[0] = 5'd3; wd[0] = 32'h33; rsv_en = 1'b1; rsv_idx = 5'd3;
    rd_en = 2'b11; ridx[0] = 5'd3; ridx[1] = 5'd3;
    cycle();
    chk("rsv_beats_clear", 32'(bv_b[3]), 32'd1);
    idle(); w_en = 2'b01; widx[0] = 5'd3; wd[0] = 32'h34;
    cycle();
    chk("write_clears", 32'(bv_b[3]), 32'd0);

    idle(); rsv_en = 1'b1; rsv_idx = 5'd4;
    cycle();
    idle(); rsv_en = 1'b1; rsv_idx = 5'd9;
    cycle();
    idle(); flush = 1'b1; rsv_en = 1'b1; rsv_idx = 5'd6;
    w_en = 2'b10; widx[1] = 5'd9; wd[1] = 32'h99;
    cycle();
    chk("flush_clears_all", bv_b, 32'd0);
    idle(); rd_en = 2'b11; ridx[0] = 5'd9; ridx[1] = 5'd6;
    #1;
    chk("flush_write_commits", rdd_n[31:0], 32'h99);
    cycle();

    for (int n = 0; n < 400; n++) begin
      idle();
      rstn    = ($urandom_range(0, 59) != 0);
      flush   = ($urandom_range(0, 19) == 0);
      w_en    = 2'($urandom);
      widx[0] = 5'($urandom); widx[1] = ($urandom_range(0, 3) == 0) ? widx[0] : 5'($urandom);
      wd[0]   = $urandom; wd[1] = $urandom;
      rsv_en  = 1'($urandom); rsv_idx = 5'($urandom);
      rd_en   = 2'($urandom);
      ridx[0] = 5'($urandom); ridx[1] = ($urandom_range(0, 2) == 0) ? widx[0] : 5'($urandom);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
